// File: rtl/sine_voice_scheduler.sv
// Shares one registered sine LUT across NUM_VOICES phase-accumulator voices and mixes them per sample tick.
// Optional per-voice volume scaling: define SINE_SCHED_VOLUME_EN.
module sine_voice_scheduler #(
  parameter int NUM_VOICES = 4,
  parameter int VW         = $clog2(NUM_VOICES),
  parameter int MIX_W      = 16 + VW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_tick,
  input  logic             cfg_we,
  input  logic [VW-1:0]    cfg_voice,
  input  logic [31:0]      cfg_inc,
  input  logic             cfg_en,
  input  logic [7:0]       cfg_vol,
  output logic [8:0]       lut_addr,
  input  logic [15:0]      lut_data,
  output logic [15:0]      voice_sample,
  output logic [VW-1:0]    voice_idx,
  output logic             voice_valid,
  output logic [MIX_W-1:0] mix_out,
  output logic             mix_valid,
  output logic             busy,
  output logic             overrun
);

  localparam int CW = VW + 1;
  localparam logic [CW-1:0] ISSUE_END = CW'(NUM_VOICES);
  localparam logic [CW-1:0] RUN_END   = CW'(NUM_VOICES + 1);
  localparam logic [VW-1:0] LAST_IDX  = VW'(NUM_VOICES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [31:0]           phase [NUM_VOICES];
  logic [31:0]           inc   [NUM_VOICES];
  logic [NUM_VOICES-1:0] en;

  logic                  iss_valid, iss_en, dat_valid, dat_en, voice_en;
  logic [VW-1:0]         iss_idx, dat_idx, issue_k;
  logic                  issue_now, tick_accept, cfg_ok;
  logic [15:0]           cap_sample;
  logic [MIX_W-1:0]      acc, contrib;

  assign tick_accept = (state == IDLE) && sample_tick;
  assign issue_now   = tick_accept || ((state == RUN) && (cnt < ISSUE_END));
  assign issue_k     = (state == IDLE) ? '0 : cnt[VW-1:0];
  assign cfg_ok      = cfg_we && ({1'b0, cfg_voice} < ISSUE_END);

`ifdef SINE_SCHED_VOLUME_EN
  logic [7:0]         vol [NUM_VOICES];
  logic [7:0]         iss_vol, dat_vol;
  logic signed [24:0] prod;

  // Volume is carried down the pipeline with the voice tag so the scale matches the issued voice.
  assign prod       = $signed(lut_data) * $signed({1'b0, dat_vol});
  assign cap_sample = 16'(prod >>> 8);
`else
  logic unused_vol;

  assign unused_vol = ^cfg_vol;
  assign cap_sample = lut_data;
`endif

  assign contrib = voice_en ? {{(MIX_W-16){voice_sample[15]}}, voice_sample} : '0;

  // Sequencer, voice state and LUT issue. The config write is placed last so it overrides the
  // phase step of the same cycle; the issued address always reflects the pre-write registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      lut_addr  <= '0;
      iss_valid <= 1'b0;
      iss_idx   <= '0;
      iss_en    <= 1'b0;
      en        <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        phase[i] <= '0;
        inc[i]   <= '0;
`ifdef SINE_SCHED_VOLUME_EN
        vol[i]   <= 8'hFF;
`endif
      end
`ifdef SINE_SCHED_VOLUME_EN
      iss_vol   <= '0;
`endif
    end else begin
      iss_valid <= issue_now;
      if (issue_now) begin
        lut_addr <= phase[issue_k][31:23];
        iss_idx  <= issue_k;
        iss_en   <= en[issue_k];
`ifdef SINE_SCHED_VOLUME_EN
        iss_vol  <= vol[issue_k];
`endif
        if (en[issue_k]) phase[issue_k] <= phase[issue_k] + inc[issue_k];
      end

      if (sample_tick && (state != IDLE)) overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (sample_tick) begin
            state <= RUN;
            cnt   <= CW'(1);
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (cnt == RUN_END) state <= DRAIN;
          else                cnt   <= cnt + CW'(1);
        end
        DRAIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (cfg_ok) begin
        inc[cfg_voice] <= cfg_inc;
        en[cfg_voice]  <= cfg_en;
`ifdef SINE_SCHED_VOLUME_EN
        vol[cfg_voice] <= cfg_vol;
`endif
        if (!cfg_en) phase[cfg_voice] <= '0;
      end
    end
  end

  // Capture and mix: the tag follows the LUT's one-cycle latency, then the last voice closes the mix.
  always_ff @(posedge clk) begin
    if (reset) begin
      dat_valid    <= 1'b0;
      dat_idx      <= '0;
      dat_en       <= 1'b0;
      voice_valid  <= 1'b0;
      voice_idx    <= '0;
      voice_sample <= '0;
      voice_en     <= 1'b0;
      acc          <= '0;
      mix_out      <= '0;
      mix_valid    <= 1'b0;
`ifdef SINE_SCHED_VOLUME_EN
      dat_vol      <= '0;
`endif
    end else begin
      dat_valid   <= iss_valid;
      dat_idx     <= iss_idx;
      dat_en      <= iss_en;
`ifdef SINE_SCHED_VOLUME_EN
      dat_vol     <= iss_vol;
`endif
      voice_valid <= dat_valid;
      mix_valid   <= 1'b0;
      if (dat_valid) begin
        voice_sample <= cap_sample;
        voice_idx    <= dat_idx;
        voice_en     <= dat_en;
      end
      if (tick_accept) begin
        acc <= '0;
      end else if (voice_valid) begin
        if (voice_idx == LAST_IDX) begin
          mix_out   <= acc + contrib;
          mix_valid <= 1'b1;
        end else begin
          acc <= acc + contrib;
        end
      end
    end
  end

endmodule
